// File: rtl/video_mode_ctrl.sv
// Sequences PAL/NTSC and scandouble changes into mycore at vblank, pulses the core reset,
// waits for the raster to settle, and frame-aligns the R/G/B enables.
module video_mode_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int VBL_TIMEOUT   = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pal_req,
  input  logic       scandouble_req,
  input  logic [1:0] col_sel,
  input  logic       joy_en,
  input  logic [2:0] joy_rgb,
  input  logic       vblank,
  input  logic       vsync,
  output logic       pal,
  output logic       scandouble,
  output logic       core_reset,
  output logic [2:0] rgb_en,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CNT_W = $clog2(RST_CYCLES) + 1;
  localparam int FRM_W = $clog2(SETTLE_FRAMES) + 1;
  localparam int TMR_W = $clog2(VBL_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SETTLE_FRAMES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(VBL_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VBL, RST_CORE, SETTLE} state_t;

  state_t           state;
  logic [1:0]       pend;
  logic [CNT_W-1:0] cnt;
  logic [FRM_W-1:0] frames;
  logic [TMR_W-1:0] timer;
  logic             vblank_q, vsync_q;
  logic             vbl_rise, vs_rise;
  logic [2:0]       rgb_q, target;
  logic [1:0]       req, applied;

  assign vbl_rise = vblank & ~vblank_q;
  assign vs_rise  = vsync & ~vsync_q;
  assign req      = {pal_req, scandouble_req};
  assign applied  = {pal, scandouble};

  always_comb begin
    target = 3'b111;
    if (joy_en) begin
      target = joy_rgb;
    end else begin
      case (col_sel)
        2'd1:    target = 3'b001;
        2'd2:    target = 3'b010;
        2'd3:    target = 3'b100;
        default: target = 3'b111;
      endcase
    end
  end

  // The picture is blanked while the core is held in reset or still settling.
  assign rgb_en = (state == RST_CORE || state == SETTLE) ? 3'b000 : rgb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST_CORE;
      pal         <= 1'b0;
      scandouble  <= 1'b0;
      core_reset  <= 1'b1;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
      rgb_q       <= 3'b111;
      pend        <= 2'b00;
      cnt         <= '0;
      frames      <= '0;
      timer       <= '0;
      vblank_q    <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      vblank_q <= vblank;
      vsync_q  <= vsync;
      if (vbl_rise) rgb_q <= target;

      case (state)
        IDLE: begin
          if (req != applied) begin
            pend  <= req;
            timer <= '0;
            busy  <= 1'b1;
            state <= WAIT_VBL;
          end
        end

        WAIT_VBL: begin
          pend  <= req;
          timer <= (timer == '1) ? timer : timer + TMR_W'(1);
          // A request that reverts to the applied mode cancels without touching the core.
          if (req == applied) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (vbl_rise || timer == TMR_LAST) begin
            {pal, scandouble} <= pend;
            core_reset        <= 1'b1;
            cnt               <= '0;
            timer             <= '0;
            state             <= RST_CORE;
            if (!vbl_rise) timeout_err <= 1'b1;
          end
        end

        RST_CORE: begin
          if (cnt == CNT_LAST) begin
            core_reset <= 1'b0;
            frames     <= '0;
            timer      <= '0;
            state      <= SETTLE;
          end else begin
            cnt <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
          end
        end

        SETTLE: begin
          if (vs_rise) begin
            timer <= '0;
            if (frames == FRM_LAST) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              frames <= (frames == '1) ? frames : frames + FRM_W'(1);
            end
          end else if (timer == TMR_LAST) begin
            timer       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= (timer == '1) ? timer : timer + TMR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomized scoreboard bench for video_mode_ctrl: a countdown-style reference model
// predicts every output change and its cycle; a negedge monitor pops and compares.
module tb_video_mode_ctrl;

  localparam int RST_CYCLES    = 16;
  localparam int SETTLE_FRAMES = 2;
  localparam int VBL_TIMEOUT   = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pal_req, scandouble_req, joy_en, vblank, vsync;
  logic [1:0] col_sel;
  logic [2:0] joy_rgb;
  logic       pal, scandouble, core_reset, busy, timeout_err;
  logic [2:0] rgb_en;

  always #5 clk = ~clk;

  video_mode_ctrl #(
    .RST_CYCLES(RST_CYCLES), .SETTLE_FRAMES(SETTLE_FRAMES), .VBL_TIMEOUT(VBL_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pal_req(pal_req), .scandouble_req(scandouble_req),
    .col_sel(col_sel), .joy_en(joy_en), .joy_rgb(joy_rgb), .vblank(vblank), .vsync(vsync),
    .pal(pal), .scandouble(scandouble), .core_reset(core_reset), .rgb_en(rgb_en),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 0;
  logic [7:0] last_pushed;
  bit         pushed_any = 0;

  // Reference model: the core is "in reset" while reset_left>0, "settling" while frames_left>0.
  bit         m_pal, m_sd, m_core_reset, m_busy, m_err, m_waiting, m_prev_vbl, m_prev_vs;
  logic [1:0] m_pend;
  logic [2:0] m_rgb;
  int         m_reset_left, m_frames_left, m_wait_age, m_quiet;

  // Video raster generator state.
  int pos = 0, flen = 60, stall = 0, toggle_back = 0;

  function automatic logic [2:0] colour_of(input logic [1:0] c);
    case (c)
      2'd0:    return 3'b111;
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [7:0] model_vec();
    logic [2:0] shown;
    shown = (m_reset_left > 0 || m_frames_left > 0) ? 3'b000 : m_rgb;
    return {m_pal, m_sd, m_core_reset, m_busy, m_err, shown};
  endfunction

  task automatic model_reset();
    m_pal = 0; m_sd = 0; m_core_reset = 1; m_busy = 1; m_err = 0; m_rgb = 3'b111;
    m_waiting = 0; m_pend = 2'b00; m_reset_left = RST_CYCLES; m_frames_left = 0;
    m_wait_age = 0; m_quiet = 0; m_prev_vbl = 0; m_prev_vs = 0;
  endtask

  task automatic model_step();
    bit         vr, sr;
    logic [1:0] req;
    if (!reset_n) begin
      model_reset();
      return;
    end
    vr  = vblank && !m_prev_vbl;
    sr  = vsync && !m_prev_vs;
    req = {pal_req, scandouble_req};
    if (vr) m_rgb = joy_en ? joy_rgb : colour_of(col_sel);
    if (m_reset_left > 0) begin
      m_reset_left--;
      if (m_reset_left == 0) begin
        m_core_reset = 0; m_frames_left = SETTLE_FRAMES; m_quiet = 0;
      end
    end else if (m_frames_left > 0) begin
      if (sr) begin
        m_frames_left--; m_quiet = 0;
        if (m_frames_left == 0) m_busy = 0;
      end else if (m_quiet == VBL_TIMEOUT - 1) begin
        m_frames_left = 0; m_busy = 0; m_err = 1;
      end else begin
        m_quiet++;
      end
    end else if (m_waiting) begin
      if (req == {m_pal, m_sd}) begin
        m_waiting = 0; m_busy = 0;
      end else if (vr || m_wait_age == VBL_TIMEOUT - 1) begin
        {m_pal, m_sd} = m_pend;
        m_waiting = 0; m_reset_left = RST_CYCLES; m_core_reset = 1;
        if (!vr) m_err = 1;
      end else begin
        m_wait_age++;
      end
      m_pend = req;
    end else if (req != {m_pal, m_sd}) begin
      m_waiting = 1; m_pend = req; m_wait_age = 0; m_busy = 1;
    end
    m_prev_vbl = vblank;
    m_prev_vs  = vsync;
  endtask

  task automatic push_if_changed();
    logic [7:0] v;
    exp_t       e;
    v = model_vec();
    if (!pushed_any || v != last_pushed) begin
      e.cyc = cyc;
      e.v   = v;
      exp_q.push_back(e);
      last_pushed = v;
      pushed_any  = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    push_if_changed();
  endtask

  task automatic drive_video();
    if (stall > 0) begin
      stall--;
      vblank = 0;
      vsync  = 0;
      return;
    end
    vblank = (pos >= flen - 8);
    vsync  = (pos >= flen - 5) && (pos < flen - 3);
    pos++;
    if (pos >= flen) begin
      pos  = 0;
      flen = $urandom_range(40, 90);
    end
  endtask

  task automatic apply_stimulus(input int n, input bit rand_req);
    for (int i = 0; i < n; i++) begin
      if (rand_req) begin
        if (toggle_back > 0) begin
          toggle_back--;
          if (toggle_back == 0) pal_req = ~pal_req;
        end else if ($urandom_range(0, 149) == 0) begin
          pal_req     = ~pal_req;
          toggle_back = $urandom_range(1, 9);
        end else if ($urandom_range(0, 79) == 0) begin
          pal_req = ~pal_req;
        end
        if ($urandom_range(0, 79) == 0) scandouble_req = ~scandouble_req;
        if ($urandom_range(0, 49) == 0) col_sel = 2'($urandom);
        if ($urandom_range(0, 99) == 0) joy_en = ~joy_en;
        if ($urandom_range(0, 39) == 0) joy_rgb = 3'($urandom);
        if (stall == 0 && $urandom_range(0, 399) == 0) stall = $urandom_range(60, 250);
      end
      drive_video();
      tick();
    end
  endtask

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic wait_model_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((m_waiting || m_reset_left > 0 || m_frames_left > 0) && n < budget) begin
      apply_stimulus(1, 0);
      n++;
    end
    if (n >= budget) check_output(name, 8'd1, 8'd0);
  endtask

  always @(negedge clk) begin
    logic [7:0] now;
    logic [7:0] seen;
    exp_t       e;
    if (mon_en) begin
      now = {pal, scandouble, core_reset, busy, timeout_err, rgb_en};
      if (checks == 0 && exp_q.size() > 0 && seen === 8'bx) seen = ~now;
      if (now !== seen) begin
        seen = now;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_unexpected cyc=%0d: got %b, expected no change", cyc, now);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v !== now) begin
            errors++;
            $display("[TB] FAIL scoreboard cyc=%0d: got %b, expected %b at cyc %0d",
                     cyc, now, e.v, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 0; pal_req = 0; scandouble_req = 0; joy_en = 0; joy_rgb = 3'b000;
    col_sel = 2'd0; vblank = 0; vsync = 0;
    model_reset();
    tick();
    mon_en = 1;
    apply_stimulus(2, 0);
    #1 reset_n = 1;

    // Power-up: core reset, settle on vsync, then idle with white enables.
    apply_stimulus(300, 0);
    check_output("t1_idle", {pal, core_reset, busy, rgb_en}, {4'b0000, 3'b111} & 7'h7F);

    // Colour gating and mode changes under random requests and raster stalls.
    apply_stimulus(4000, 1);

    // Frozen raster: the pending change must be forced by the timeout.
    toggle_back = 0;
    wait_model_idle("t4_reach_idle", 1000);
    stall = 260;
    scandouble_req = ~scandouble_req;
    apply_stimulus(260, 0);
    check_output("t4_timeout_err", {7'd0, timeout_err}, 8'd1);
    check_output("t4_scandouble", {7'd0, scandouble}, {7'd0, m_sd});

    // Asynchronous reset while the core is held in reset after a mode change.
    wait_model_idle("t6_reach_idle", 1000);
    pal_req = ~pal_req;
    begin
      int n;
      n = 0;
      while (!(m_reset_left > 0 && m_reset_left < RST_CYCLES) && n < 1000) begin
        apply_stimulus(1, 0);
        n++;
      end
      if (n >= 1000) check_output("t6_reach_rst_core", 8'd1, 8'd0);
    end
    #1 reset_n = 0;
    model_reset();
    push_if_changed();
    #1;
    check_output("t6_async_reset", {5'd0, pal, core_reset, busy}, 8'b0000_0011);
    check_output("t6_rgb_muted", {5'd0, rgb_en}, 8'd0);
    apply_stimulus(3, 0);
    #1 reset_n = 1;
    apply_stimulus(300, 0);
    apply_stimulus(3000, 1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
